// File: rtl/la_pkg.sv
// la_pkg: shared definitions for the logic-analyser command path.
//   - command code constants
//   - default packet header
//   - command decoder FSM state enum
//   - payload length lookup
package la_pkg;

  localparam logic [15:0] HEADER_DEFAULT = 16'hAA55;

  localparam logic [7:0] CMD_SET_SAMPLES = 8'h01;
  localparam logic [7:0] CMD_SET_MASK    = 8'h02;
  localparam logic [7:0] CMD_SET_VALUE   = 8'h03;
  localparam logic [7:0] CMD_ARM         = 8'h04;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_CMD,
    ST_PAYLOAD,
    ST_DISCARD
  } la_state_e;

  function automatic logic cmd_known(input logic [7:0] cmd);
    case (cmd)
      CMD_SET_SAMPLES, CMD_SET_MASK, CMD_SET_VALUE, CMD_ARM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Payload length in bytes; nb is the probe width in bytes.
  // Unknown codes return 0, callers gate with cmd_known().
  function automatic logic [3:0] payload_len(input logic [7:0] cmd, input int unsigned nb);
    case (cmd)
      CMD_SET_SAMPLES:             return 4'd1;
      CMD_SET_MASK, CMD_SET_VALUE: return 4'(nb);
      default:                     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/la_command_decoder.sv
// la_command_decoder: parses inbound byte-fragmented command packets and
// drives the analyser configuration.
//
// Packet: HEADER[7:0], HEADER[15:8], command, payload (LSB byte first),
// with bits_last on the final byte.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   io_packetSlave_ready               byte accept (1 whenever not in reset)
//   io_packetSlave_valid               byte valid
//   io_packetSlave_bits_last           final byte of packet
//   io_packetSlave_bits_fragment [7:0] data byte
//   io_config_samplesLeftAfterTrigger  post-trigger sample count
//   io_config_triggerMask              trigger compare mask
//   io_config_triggerValue             trigger compare value
//   io_arm                             one-cycle arm strobe
//   io_errorCount                      saturating count of rejected packets
//
// Handshake: a byte transfers on every rising clk edge where valid and ready
// are both high. Ready does not depend on valid; valid low means no byte and
// leaves all parser state (FSM, index, shadow) untouched.
module la_command_decoder
  import la_pkg::*;
#(
  parameter int unsigned PROBE_WIDTH   = 48,
  parameter logic [15:0] HEADER        = HEADER_DEFAULT,
  parameter logic [7:0]  SAMPLES_RESET = 8'h80
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   io_packetSlave_ready,
  input  logic                   io_packetSlave_valid,
  input  logic                   io_packetSlave_bits_last,
  input  logic [7:0]             io_packetSlave_bits_fragment,
  output logic [7:0]             io_config_samplesLeftAfterTrigger,
  output logic [PROBE_WIDTH-1:0] io_config_triggerMask,
  output logic [PROBE_WIDTH-1:0] io_config_triggerValue,
  output logic                   io_arm,
  output logic [7:0]             io_errorCount
);

  localparam int unsigned NB = PROBE_WIDTH / 8;

  la_state_e              state;
  logic [2:0]             idx;
  logic [7:0]             cmd_q;
  logic [PROBE_WIDTH-1:0] shadow;
  logic [PROBE_WIDTH-1:0] shadow_next;
  logic                   hs;
  logic [7:0]             frag;
  logic                   last;
  logic [3:0]             len_in;
  logic [3:0]             len_cmd;

  assign io_packetSlave_ready = ~reset;
  assign hs      = io_packetSlave_valid & io_packetSlave_ready;
  assign frag    = io_packetSlave_bits_fragment;
  assign last    = io_packetSlave_bits_last;
  assign len_in  = payload_len(frag, NB);
  assign len_cmd = payload_len(cmd_q, NB);

  // Shadow with the current payload byte merged at its index, so a commit
  // on the final byte sees the complete payload in the same cycle.
  always_comb begin
    shadow_next = shadow;
    for (int b = 0; b < int'(NB); b++) begin
      if (idx == 3'(b)) shadow_next[b*8 +: 8] = frag;
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state                             <= ST_HDR0;
      idx                               <= '0;
      cmd_q                             <= '0;
      shadow                            <= '0;
      io_config_samplesLeftAfterTrigger <= SAMPLES_RESET;
      io_config_triggerMask             <= '0;
      io_config_triggerValue            <= '0;
      io_arm                            <= 1'b0;
      io_errorCount                     <= '0;
    end else begin
      io_arm <= 1'b0;
      if (hs) begin
        case (state)
          ST_HDR0, ST_HDR1: begin
            if (frag == ((state == ST_HDR0) ? HEADER[7:0] : HEADER[15:8]) && !last) begin
              state <= (state == ST_HDR0) ? ST_HDR1 : ST_CMD;
            end else if (last) begin
              io_errorCount <= sat_inc(io_errorCount);
              state         <= ST_HDR0;
            end else begin
              state <= ST_DISCARD;
            end
          end
          ST_CMD: begin
            cmd_q <= frag;
            idx   <= '0;
            if (!cmd_known(frag) || (len_in != 4'd0 && last)) begin
              // Unknown code, or a payload command that ended with no payload.
              if (last) begin
                io_errorCount <= sat_inc(io_errorCount);
                state         <= ST_HDR0;
              end else begin
                state <= ST_DISCARD;
              end
            end else if (len_in == 4'd0) begin
              if (last) begin
                io_arm <= 1'b1;
                state  <= ST_HDR0;
              end else begin
                state <= ST_DISCARD;
              end
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            shadow <= shadow_next;
            idx    <= idx + 3'd1;
            if ({1'b0, idx} == len_cmd - 4'd1) begin
              if (last) begin
                case (cmd_q)
                  CMD_SET_SAMPLES: io_config_samplesLeftAfterTrigger <= shadow_next[7:0];
                  CMD_SET_MASK:    io_config_triggerMask             <= shadow_next;
                  CMD_SET_VALUE:   io_config_triggerValue            <= shadow_next;
                  default:         ;
                endcase
                state <= ST_HDR0;
              end else begin
                state <= ST_DISCARD;
              end
            end else if (last) begin
              io_errorCount <= sat_inc(io_errorCount);
              state         <= ST_HDR0;
            end
          end
          ST_DISCARD: begin
            if (last) begin
              io_errorCount <= sat_inc(io_errorCount);
              state         <= ST_HDR0;
            end
          end
          default: state <= ST_HDR0;
        endcase
      end
    end
  end

endmodule

// File: doc/la_command_decoder.md
# la_command_decoder

Receives the 8-bit fragmented command packets on the logic analyser's `packetSlave` port. It validates the 16-bit packet header and decodes one command per packet. From those commands it drives the analyser configuration: post-trigger sample count, trigger mask and value, and an arm strobe. It sits between the host link and the logger, and is the inbound counterpart of the header-adder/width-adapter chain on `packetMaster`.

## Interface
- `PROBE_WIDTH`, 48: probe/trigger word width; multiple of 8.
- `HEADER`, 16'hAA55: expected header; low byte arrives first.
- `SAMPLES_RESET`, 8'h80: reset value of the sample count.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `io_packetSlave_ready` out 1: byte accept.
- `io_packetSlave_valid` in 1: byte valid.
- `io_packetSlave_bits_last` in 1: final byte of packet.
- `io_packetSlave_bits_fragment` in 8: data byte.
- `io_config_samplesLeftAfterTrigger` out 8: post-trigger sample count.
- `io_config_triggerMask` out PROBE_WIDTH: trigger compare mask.
- `io_config_triggerValue` out PROBE_WIDTH: trigger compare value.
- `io_arm` out 1: one-cycle arm strobe.
- `io_errorCount` out 8: saturating count of rejected packets.

## Operation
- Handshake = valid & ready. `ready` is 1 in every non-reset cycle; a byte is consumed every cycle valid is high.
- Packet: `HEADER[7:0]`, `HEADER[15:8]`, command byte, payload (LSB byte first), `last` on the final byte.
- Commands and payload lengths N (NB = PROBE_WIDTH/8):
  - 0x01 SET_SAMPLES: N=1.
  - 0x02 SET_MASK: N=NB.
  - 0x03 SET_VALUE: N=NB.
  - 0x04 ARM: N=0.
- Payload bytes shift into a PROBE_WIDTH shadow register. The 3-bit byte index counts payload bytes.
- FSM states: HDR0, HDR1, CMD, PAYLOAD, DISCARD. Reset state is HDR0. Transitions occur only on handshake.
  - HDR0: byte == HEADER[7:0] & !last -> HDR1. Otherwise -> DISCARD, or -> HDR0 with error if last.
  - HDR1: same rule against HEADER[15:8]; match -> CMD.
  - CMD, unknown code: error path (DISCARD, or HDR0 with error if last).
  - CMD, N=0: requires last -> commit, HDR0. Without last -> DISCARD.
  - CMD, N>0: requires !last -> PAYLOAD, index=0.
  - PAYLOAD, byte index N-1 with last -> commit, HDR0.
  - PAYLOAD, byte index N-1 without last -> DISCARD (too long).
  - PAYLOAD, last before index N-1 -> error, HDR0 (too short).
  - DISCARD: stay until last; at last -> error, HDR0.
- Commit:
  - SET_SAMPLES loads shadow[7:0].
  - SET_MASK / SET_VALUE load the full shadow.
  - ARM asserts `io_arm`.
- Error: `io_errorCount` increments, saturating at 8'hFF. Config registers are untouched; a partial payload never reaches outputs.

## Timing
- Reset values:
  - samples = SAMPLES_RESET.
  - mask = 0, value = 0.
  - arm = 0, errorCount = 0, ready = 0 during reset.
  - state = HDR0, shadow = 0.
- Config outputs are registered. They change the cycle after the committing last-byte handshake.
- `io_arm` is high exactly that one cycle.
- Error count updates the cycle after the erroring last-byte handshake.
- A single-byte packet (last in HDR0) counts as one error.
- Back-to-back packets need no idle cycle. A byte following a last is parsed as HDR0.
- Reset mid-packet: the partial packet is dropped, no error is counted, and all config returns to reset values.
- `valid` low leaves state, index and shadow unchanged.

## Structure
- Shared package `la_pkg`:
  - command code constants.
  - `HEADER` default.
  - FSM state enum.
  - payload-length function.
- Single module; no sub-module is warranted. Shadow register and index live inline.

## Test plan
- Send 55 AA 01 20(last) -> samples 8'h20 one cycle later; arm 0; errorCount 0.
- Send 55 AA 02 01 02 03 04 05 06(last), then 55 AA 03 with six FF bytes -> mask 48'h060504030201, value 48'hFFFFFFFFFFFF.
- Send 55 AA 04(last) twice back-to-back -> two single-cycle arm pulses, one cycle apart from their last bytes.
- Error cases: bad header 55 AB 01 20(last), unknown cmd 55 AA 09(last), short 55 AA 02 11(last), long 55 AA 01 20 21(last) -> errorCount 4; config unchanged.
- Send 300 single-byte last packets -> errorCount saturates at 8'hFF.
- Assert reset after 55 AA 02 01 -> config at reset values. Then 55 AA 01 07(last) -> samples 8'h07, errorCount 0.
